// File: rtl/bram_capture_ctrl.sv
// Sample capture controller for a single-port BRAM: records a burst of samples, then serves indexed reads.
// Build option: define BRAM_CAPTURE_WRAP_EN for circular capture (keeps the newest RAM_DEPTH samples).
module bram_capture_ctrl #(
    parameter int RAM_WIDTH  = 18,
    parameter int RAM_DEPTH  = 1024,
    parameter int RD_LATENCY = 2,
    // Bits needed to hold RAM_DEPTH-1.
    localparam int ADDR_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic                 i_valid,
    input  logic [RAM_WIDTH-1:0] i_data,
    input  logic                 i_rd_req,
    input  logic [ADDR_W-1:0]    i_rd_addr,
    input  logic                 i_clear,
    output logic                 o_ram_ena,
    output logic                 o_ram_wea,
    output logic                 o_ram_regcea,
    output logic                 o_ram_rsta,
    output logic [ADDR_W-1:0]    o_ram_addr,
    output logic [RAM_WIDTH-1:0] o_ram_din,
    input  logic [RAM_WIDTH-1:0] i_ram_dout,
    output logic                 o_rd_valid,
    output logic [RAM_WIDTH-1:0] o_rd_data,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [ADDR_W:0]      o_count
);

`ifdef BRAM_CAPTURE_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(RAM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_W-1:0]     r_wr_ptr;
    logic [ADDR_W:0]       r_count;
    logic                  r_wrapped;
    logic [RD_LATENCY-1:0] r_vpipe;

    logic                  w_wr;
    logic                  w_rd;
    logic                  w_last;
    logic [ADDR_W:0]       w_rd_sum;
    logic [ADDR_W:0]       w_rd_mod;
    logic [ADDR_W-1:0]     w_rd_phys;

    // Strobes are gated by rst_n so nothing reaches the RAM in a reset cycle.
    assign w_wr   = rst_n && (r_state == S_CAPTURE) && i_valid;
    assign w_rd   = rst_n && (r_state == S_DONE) && i_rd_req;
    assign w_last = (r_wr_ptr == LAST_ADDR);

    // Once wrapped, the oldest sample sits at wr_ptr.
    assign w_rd_sum  = {1'b0, r_wr_ptr} + {1'b0, i_rd_addr};
    assign w_rd_mod  = (w_rd_sum >= DEPTH_W) ? (w_rd_sum - DEPTH_W) : w_rd_sum;
    assign w_rd_phys = r_wrapped ? w_rd_mod[ADDR_W-1:0] : i_rd_addr;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_next = S_CAPTURE;
            S_CAPTURE: if (i_stop || (w_wr && w_last && !WRAP_EN)) w_next = S_DONE;
            S_DONE:    if (i_clear) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_wrapped <= 1'b0;
            r_vpipe   <= '0;
        end else begin
            r_state    <= w_next;
            r_vpipe[0] <= w_rd;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
            if ((r_state == S_DONE) && i_clear) begin
                r_wr_ptr  <= '0;
                r_count   <= '0;
                r_wrapped <= 1'b0;
            end else if (w_wr) begin
                r_wr_ptr <= w_last ? '0 : r_wr_ptr + 1'b1;
                if (w_last && WRAP_EN) begin
                    r_wrapped <= 1'b1;
                end
                if (r_count != DEPTH_W) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign o_ram_ena    = w_wr || w_rd;
    assign o_ram_wea    = w_wr;
    assign o_ram_addr   = w_wr ? r_wr_ptr : w_rd_phys;
    assign o_ram_din    = i_data;
    assign o_ram_regcea = 1'b1;
    assign o_ram_rsta   = ~rst_n;

    assign o_rd_valid = rst_n && r_vpipe[RD_LATENCY-1];
    assign o_rd_data  = i_ram_dout;
    assign o_busy     = rst_n && (r_state == S_CAPTURE);
    assign o_done     = rst_n && (r_state == S_DONE);
    assign o_count    = r_count;

endmodule

// File: tb/tb_bram_capture_ctrl.sv
// Bench for bram_capture_ctrl: behavioural 2-cycle BRAM plus write/read scoreboards checked on the falling edge.
module tb_bram_capture_ctrl;
    localparam int W     = 18;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk;
    logic          rst_n;
    logic          i_start, i_stop, i_valid, i_rd_req, i_clear;
    logic [W-1:0]  i_data;
    logic [AW-1:0] i_rd_addr;
    logic          o_ram_ena, o_ram_wea, o_ram_regcea, o_ram_rsta;
    logic [AW-1:0] o_ram_addr;
    logic [W-1:0]  o_ram_din, i_ram_dout, o_rd_data;
    logic          o_rd_valid, o_busy, o_done;
    logic [AW:0]   o_count;

    bram_capture_ctrl #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .RD_LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_stop(i_stop),
        .i_valid(i_valid), .i_data(i_data), .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr),
        .i_clear(i_clear), .o_ram_ena(o_ram_ena), .o_ram_wea(o_ram_wea),
        .o_ram_regcea(o_ram_regcea), .o_ram_rsta(o_ram_rsta), .o_ram_addr(o_ram_addr),
        .o_ram_din(o_ram_din), .i_ram_dout(i_ram_dout), .o_rd_valid(o_rd_valid),
        .o_rd_data(o_rd_data), .o_busy(o_busy), .o_done(o_done), .o_count(o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port BRAM with output register: data two cycles after address.
    logic [W-1:0] mem [0:DEPTH-1];
    logic [W-1:0] ram_r1;
    always @(posedge clk) begin
        if (o_ram_ena) begin
            if (o_ram_wea) mem[o_ram_addr] <= o_ram_din;
            ram_r1 <= mem[o_ram_addr];
        end
        if (o_ram_rsta)        i_ram_dout <= '0;
        else if (o_ram_regcea) i_ram_dout <= ram_r1;
    end

    typedef struct {
        int unsigned addr;
        int unsigned data;
        int          cyc;
    } exp_t;

    exp_t wq[$];
    exp_t rq[$];
    int   total = 0;
    int   bad   = 0;
    int   wr_seen = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        i_start = 0; i_stop = 0; i_valid = 0; i_rd_req = 0; i_clear = 0;
    endtask

    task automatic sample(input int d, input bit stop, input bit expw, input int addr);
        exp_t e;
        i_valid = 1; i_data = W'(d); i_stop = stop;
        if (expw) begin
            e.addr = addr; e.data = d; e.cyc = cyc;
            wq.push_back(e);
        end
        tick();
    endtask

    task automatic rd(input int a, input int d);
        exp_t e;
        i_rd_req = 1; i_rd_addr = AW'(a);
        e.addr = a; e.data = d; e.cyc = cyc + 2;
        rq.push_back(e);
        tick();
    endtask

    task automatic status(input string tag, input int busy, input int done, input int cnt);
        @(negedge clk);
        chk({tag, "_busy"}, o_busy, busy);
        chk({tag, "_done"}, o_done, done);
        chk({tag, "_count"}, o_count, cnt);
    endtask

    initial begin
        rst_n = 0; i_start = 0; i_stop = 0; i_valid = 0; i_rd_req = 0; i_clear = 0;
        i_data = '0; i_rd_addr = '0;

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (o_ram_ena && o_ram_wea) begin
                    wr_seen++;
                    if (wq.size() == 0) begin
                        chk("unexpected_write_addr", o_ram_addr, -1);
                    end else begin
                        e = wq.pop_front();
                        chk("wr_addr", o_ram_addr, e.addr);
                        chk("wr_data", o_ram_din, e.data);
                        chk("wr_cycle", cyc, e.cyc);
                    end
                end
                if (o_rd_valid) begin
                    if (rq.size() == 0) begin
                        chk("unexpected_rd_valid", o_rd_data, -1);
                    end else begin
                        e = rq.pop_front();
                        chk("rd_data", o_rd_data, e.data);
                        chk("rd_latency", cyc, e.cyc);
                    end
                end
            end
        join_none

        // Reset state
        @(negedge clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_rd_valid", o_rd_valid, 0);
        chk("rst_ena", o_ram_ena, 0);
        chk("rst_rsta", o_ram_rsta, 1);
        chk("regcea", o_ram_regcea, 1);
        tick(); tick();
        rst_n = 1;
        @(negedge clk);
        chk("rsta_released", o_ram_rsta, 0);
        status("rst", 0, 0, 0);
        tick();

        // Full capture of 1024 indexed samples
        wr_seen = 0;
        i_start = 1; tick();
        for (int k = 0; k < DEPTH; k++) begin
`ifdef BRAM_CAPTURE_WRAP_EN
            sample(k, k == DEPTH - 1, 1, k);
`else
            sample(k, 0, 1, k);
`endif
        end
        status("full", 0, 1, DEPTH);
        chk("full_writes", wr_seen, DEPTH);

        // Back-to-back reads 0..1023
        for (int a = 0; a < DEPTH; a++) rd(a, a);
        repeat (4) tick();
        chk("full_reads_drained", rq.size(), 0);

        i_clear = 1; tick();
        status("clear", 0, 0, 0);

        // Short capture, stop with 5th sample; reads during capture are dropped
        i_start = 1; tick();
        for (int k = 0; k < 5; k++) begin
            i_rd_req = 1;
            sample(100 + k, k == 4, 1, k);
        end
        status("short", 0, 1, 5);
        i_clear = 1;
        rd(4, 104);
        status("clear_inflight", 0, 0, 0);
        repeat (3) tick();
        chk("short_read_drained", rq.size(), 0);
        i_stop = 1; tick();
        status("stop_in_idle", 0, 0, 0);

        // Overfill: 1030 samples
        i_start = 1; tick();
        for (int k = 0; k < 1030; k++) begin
`ifdef BRAM_CAPTURE_WRAP_EN
            sample(k, 0, 1, k % DEPTH);
`else
            sample(k, 0, k < DEPTH, k);
`endif
        end
`ifdef BRAM_CAPTURE_WRAP_EN
        status("wrap_running", 1, 0, DEPTH);
        i_stop = 1; tick();
        status("wrap", 0, 1, DEPTH);
        rd(0, 6);
        rd(1023, 1029);
`else
        status("overfill", 0, 1, DEPTH);
        rd(0, 0);
        rd(1023, 1023);
`endif
        repeat (4) tick();
        chk("overfill_reads_drained", rq.size(), 0);
        i_start = 1; tick();
        status("start_in_done", 0, 1, DEPTH);
        i_clear = 1; tick();

        // Reset at sample 100 aborts the capture without writing
        i_start = 1; tick();
        for (int k = 0; k < 100; k++) sample(k, 0, 1, k);
        rst_n = 0; i_valid = 1; i_data = W'(100);
        @(negedge clk);
        chk("midrst_ena", o_ram_ena, 0);
        chk("midrst_wea", o_ram_wea, 0);
        chk("midrst_busy", o_busy, 0);
        tick(); tick();
        rst_n = 1;
        status("after_rst", 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            i_rd_req = 1; i_rd_addr = AW'(k); tick();
        end
        repeat (4) tick();
        @(negedge clk);
        chk("idle_no_rd_valid", o_rd_valid, 0);
        chk("wq_empty", wq.size(), 0);
        chk("rq_empty", rq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
